// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall sequencer for the five-stage core: load-use, multi-cycle EX, branch flush, halt.
// Optional STALL_CNT_EN adds a saturating stall_cycles counter port.
module pipe_hazard_ctrl #(
  parameter int REG_W  = 3,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs2,
  input  logic             id_halt,
  input  logic             ex_valid,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mc_start,
  input  logic             ex_branch_taken,
  input  logic             resume,
  output logic             pc_write,
  output logic             IF_IDwrite,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_hold,
  output logic             halted,
  output logic [1:0]       ctrl_state
`ifdef STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles
`endif
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_WAIT = 2'd1,
    DRAIN   = 2'd2,
    HALTED  = 2'd3
  } state_t;

  localparam logic [3:0] MC_LOAD = 4'(MC_LAT - 2);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       lu;

  assign lu = id_valid & ex_valid & ex_memread
            & (ex_rd != '0)
            & ((ex_rd == id_rs1)
              | (id_uses_rs2 & (ex_rd == id_rs2)));

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pc_write     = 1'b0;
    IF_IDwrite   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_hold      = 1'b0;
    halted       = 1'b0;
    unique case (state)
      RUN: begin
        if (ex_branch_taken) begin
          pc_write     = 1'b1;
          IF_IDwrite   = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (ex_mc_start) begin
          ex_hold   = 1'b1;
          cnt_nxt   = MC_LOAD;
          state_nxt = MC_WAIT;
        end else if (lu) begin
          id_ex_bubble = 1'b1;
        end else if (id_valid & id_halt) begin
          id_ex_bubble = 1'b1;
          cnt_nxt      = 4'd2;
          state_nxt    = DRAIN;
        end else begin
          pc_write   = 1'b1;
          IF_IDwrite = 1'b1;
        end
      end
      MC_WAIT: begin
        ex_hold = 1'b1;
        if (cnt == 4'd0) state_nxt = RUN;
        else cnt_nxt = cnt - 4'd1;
      end
      DRAIN: begin
        id_ex_bubble = 1'b1;
        if (cnt == 4'd0) state_nxt = HALTED;
        else cnt_nxt = cnt - 4'd1;
      end
      HALTED: begin
        halted       = 1'b1;
        id_ex_bubble = 1'b1;
        // Flush drops the HALT still sitting in IF/ID
        if (resume) begin
          pc_write    = 1'b1;
          IF_IDwrite  = 1'b1;
          if_id_flush = 1'b1;
          state_nxt   = RUN;
        end
      end
    endcase
    if (!rst_n) begin
      pc_write     = 1'b0;
      IF_IDwrite   = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b1;
      ex_hold      = 1'b0;
      halted       = 1'b0;
    end
  end

  assign ctrl_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (!pc_write && state != HALTED
                 && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (MC_LAT=4).
// Expected output vectors are queued at drive time and popped at sample time.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_uses_rs2, id_halt;
  logic [2:0] id_rs1, id_rs2, ex_rd;
  logic       ex_valid, ex_memread, ex_mc_start;
  logic       ex_branch_taken, resume;
  logic       pc_write, IF_IDwrite, if_id_flush;
  logic       id_ex_bubble, ex_hold, halted;
  logic [1:0] ctrl_state;
`ifdef STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  int passed = 0;
  int total  = 0;
  logic [7:0] sb[$];

  // Vector: {pc_write, IF_IDwrite, flush, bubble, hold, halted, state}
  localparam logic [7:0] V_RUN   = 8'b1100_0000;
  localparam logic [7:0] V_RST   = 8'b0001_0000;
  localparam logic [7:0] V_LU    = 8'b0001_0000;
  localparam logic [7:0] V_MC0   = 8'b0000_1000;
  localparam logic [7:0] V_MCW   = 8'b0000_1001;
  localparam logic [7:0] V_BR    = 8'b1111_0000;
  localparam logic [7:0] V_HLT0  = 8'b0001_0000;
  localparam logic [7:0] V_DRN   = 8'b0001_0010;
  localparam logic [7:0] V_HLTD  = 8'b0001_0111;
  localparam logic [7:0] V_RESUM = 8'b1111_0111;

  pipe_hazard_ctrl #(.REG_W(3), .MC_LAT(4), .CNT_W(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .id_valid(id_valid),
    .id_rs1(id_rs1),
    .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2),
    .id_halt(id_halt),
    .ex_valid(ex_valid),
    .ex_memread(ex_memread),
    .ex_rd(ex_rd),
    .ex_mc_start(ex_mc_start),
    .ex_branch_taken(ex_branch_taken),
    .resume(resume),
    .pc_write(pc_write),
    .IF_IDwrite(IF_IDwrite),
    .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble),
    .ex_hold(ex_hold),
    .halted(halted),
    .ctrl_state(ctrl_state)
`ifdef STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] obs();
    return {pc_write, IF_IDwrite, if_id_flush, id_ex_bubble,
            ex_hold, halted, ctrl_state};
  endfunction

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs2 = 0;
    id_halt = 0; ex_valid = 0; ex_memread = 0; ex_rd = 0;
    ex_mc_start = 0; ex_branch_taken = 0; resume = 0;
  endtask

  // Apply one load-use style input pattern and queue its expectation
  task automatic drive_lu(input logic [2:0] rd, input logic [2:0] rs1,
                          input logic [2:0] rs2, input logic use2,
                          input logic [7:0] exp);
    idle();
    id_valid = 1; ex_valid = 1; ex_memread = 1;
    ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = use2;
    sb.push_back(exp);
  endtask

  task automatic test_reset();
    logic [7:0] e;
    sb.push_back(V_RST);
    #1; e = sb.pop_front(); total++;
    if (obs() !== e) $display("FAIL reset_state got=%b exp=%b", obs(), e);
    else passed++;
    @(negedge clk); rst_n = 1; idle(); sb.push_back(V_RUN);
    #1; e = sb.pop_front(); total++;
    if (obs() !== e) $display("FAIL reset_release got=%b exp=%b", obs(), e);
    else passed++;
    @(negedge clk); ex_mc_start = 1; sb.push_back(V_MC0);
    #1; e = sb.pop_front(); total++;
    if (obs() !== e) $display("FAIL reset_mcstart got=%b exp=%b", obs(), e);
    else passed++;
    @(negedge clk); idle(); sb.push_back(V_MCW);
    #1; e = sb.pop_front(); total++;
    if (obs() !== e) $display("FAIL reset_mcwait got=%b exp=%b", obs(), e);
    else passed++;
    #1; rst_n = 0; sb.push_back(V_RST);
    #1; e = sb.pop_front(); total++;
    if (obs() !== e) $display("FAIL reset_async got=%b exp=%b", obs(), e);
    else passed++;
    @(negedge clk); sb.push_back(V_RST);
    #1; e = sb.pop_front(); total++;
    if (obs() !== e) $display("FAIL reset_held got=%b exp=%b", obs(), e);
    else passed++;
    @(negedge clk); rst_n = 1; sb.push_back(V_RUN);
    #1; e = sb.pop_front(); total++;
    if (obs() !== e) $display("FAIL reset_after got=%b exp=%b", obs(), e);
    else passed++;
    @(negedge clk); sb.push_back(V_RUN);
    #1; e = sb.pop_front(); total++;
    if (obs() !== e) $display("FAIL reset_run got=%b exp=%b", obs(), e);
    else passed++;
  endtask

  task automatic test_load_use();
    logic [7:0] e;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      unique case (i)
        0: drive_lu(3'd3, 3'd3, 3'd0, 1'b0, V_LU);
        1: begin idle(); sb.push_back(V_RUN); end
        2: drive_lu(3'd0, 3'd0, 3'd0, 1'b1, V_RUN);
        3: drive_lu(3'd3, 3'd1, 3'd3, 1'b0, V_RUN);
        4: drive_lu(3'd3, 3'd1, 3'd3, 1'b1, V_LU);
        5: drive_lu(3'd5, 3'd5, 3'd5, 1'b1, V_LU);
      endcase
      #1; e = sb.pop_front(); total++;
      if (obs() !== e)
        $display("FAIL load_use[%0d] got=%b exp=%b", i, obs(), e);
      else passed++;
    end
    @(negedge clk); idle();
  endtask

  task automatic test_multicycle();
    logic [7:0] e;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); idle();
      if (i == 0) begin ex_mc_start = 1; sb.push_back(V_MC0); end
      else if (i < 4) begin
        ex_branch_taken = (i == 2);
        id_valid = 1; id_halt = (i == 3);
        sb.push_back(V_MCW);
      end else sb.push_back(V_RUN);
      #1; e = sb.pop_front(); total++;
      if (obs() !== e)
        $display("FAIL multicycle[%0d] got=%b exp=%b", i, obs(), e);
      else passed++;
    end
  endtask

  task automatic test_branch_priority();
    logic [7:0] e;
    @(negedge clk);
    drive_lu(3'd2, 3'd2, 3'd0, 1'b0, V_BR);
    id_halt = 1; ex_branch_taken = 1; ex_mc_start = 1;
    #1; e = sb.pop_front(); total++;
    if (obs() !== e) $display("FAIL branch_prio got=%b exp=%b", obs(), e);
    else passed++;
    @(negedge clk); idle(); sb.push_back(V_RUN);
    #1; e = sb.pop_front(); total++;
    if (obs() !== e) $display("FAIL branch_next got=%b exp=%b", obs(), e);
    else passed++;
  endtask

  task automatic test_halt_resume();
    logic [7:0] e;
    @(negedge clk); idle(); resume = 1; sb.push_back(V_RUN);
    #1; e = sb.pop_front(); total++;
    if (obs() !== e) $display("FAIL resume_in_run got=%b exp=%b", obs(), e);
    else passed++;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); idle();
      id_valid = (c < 6); id_halt = (c < 6);
      resume = (c == 6);
      if (c == 0) sb.push_back(V_HLT0);
      else if (c < 4) sb.push_back(V_DRN);
      else if (c < 6) sb.push_back(V_HLTD);
      else if (c == 6) sb.push_back(V_RESUM);
      else sb.push_back(V_RUN);
      #1; e = sb.pop_front(); total++;
      if (obs() !== e)
        $display("FAIL halt[%0d] got=%b exp=%b", c, obs(), e);
      else passed++;
    end
  endtask

`ifdef STALL_CNT_EN
  task automatic test_stall_cnt();
    logic [15:0] exp_cnt;
    @(negedge clk); idle(); rst_n = 0;
    @(negedge clk); rst_n = 1;
    @(negedge clk); ex_mc_start = 1;
    @(negedge clk); idle();
    repeat (3) @(negedge clk);
    drive_lu(3'd4, 3'd4, 3'd0, 1'b0, V_LU);
    void'(sb.pop_front());
    @(negedge clk); idle();
    @(negedge clk);
    exp_cnt = 16'd5; total++;
    if (stall_cycles !== exp_cnt)
      $display("FAIL stall_cnt got=%0d exp=%0d", stall_cycles, exp_cnt);
    else passed++;
    id_valid = 1; id_halt = 1;
    @(negedge clk); idle();
    repeat (6) @(negedge clk);
    resume = 1;
    @(negedge clk); idle();
    @(negedge clk);
    exp_cnt = 16'd9; total++;
    if (stall_cycles !== exp_cnt)
      $display("FAIL stall_halt got=%0d exp=%0d", stall_cycles, exp_cnt);
    else passed++;
  endtask
`endif

  initial begin
    rst_n = 0;
    idle();
    @(posedge clk);
    @(negedge clk);
    test_reset();
    test_load_use();
    test_multicycle();
    test_branch_priority();
    test_halt_resume();
`ifdef STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard and stall controller for the 19-bit, 8-bit-PC five-stage CPU. Drives the `IF_IDwrite` enable on the IF/ID register, plus the PC write enable and the IF/ID and ID/EX squash controls. It sequences four events: load-use stalls, multi-cycle EX operations, taken-branch flushes, and halt/resume. It sits beside the IF/ID and ID/EX registers and takes decoded fields from ID and EX.

## Interface
Parameters:
- REG_W, 3, register-index width
- MC_LAT, 4, total cycles a multi-cycle op occupies EX (legal 2..15)
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs1  in  REG_W  ID source register 1
- id_rs2  in  REG_W  ID source register 2
- id_uses_rs2  in  1  ID instruction reads rs2
- id_halt  in  1  ID instruction is HALT
- ex_valid  in  1  EX holds a real instruction
- ex_memread  in  1  EX instruction is a load
- ex_rd  in  REG_W  EX destination register
- ex_mc_start  in  1  multi-cycle op entered EX this cycle (single-cycle pulse)
- ex_branch_taken  in  1  branch in EX resolved taken
- resume  in  1  restart from halt (pulse)
- pc_write  out  1  PC register load enable
- IF_IDwrite  out  1  IF/ID register load enable
- if_id_flush  out  1  load NOP into IF/ID
- id_ex_bubble  out  1  load NOP into ID/EX
- ex_hold  out  1  freeze EX stage and ID/EX
- halted  out  1  core halted
- ctrl_state  out  2  current state: RUN=0, MC_WAIT=1, DRAIN=2, HALTED=3

## Operation
- Load-use hazard LU = id_valid & ex_valid & ex_memread & (ex_rd != 0) & (ex_rd == id_rs1 | (id_uses_rs2 & ex_rd == id_rs2)).
- Default output values are all 0, except that `pc_write` and `IF_IDwrite` are 1 in normal RUN flow.
- RUN evaluates the following in strict priority order:
  1. ex_branch_taken: pc_write=1, IF_IDwrite=1, if_id_flush=1, id_ex_bubble=1. LU, halt and ex_mc_start are ignored. Next state RUN.
  2. ex_mc_start: pc_write=0, IF_IDwrite=0, ex_hold=1. Load cnt=MC_LAT-2. Next state MC_WAIT.
  3. LU: pc_write=0, IF_IDwrite=0, id_ex_bubble=1. Next state RUN. This gives a one-cycle bubble that repeats while LU stays true.
  4. id_valid & id_halt: pc_write=0, IF_IDwrite=0, id_ex_bubble=1. Load cnt=2. Next state DRAIN.
  5. Otherwise: pc_write=1, IF_IDwrite=1.
- MC_WAIT: pc_write=0, IF_IDwrite=0, ex_hold=1. ex_branch_taken, LU and halt are ignored. cnt decrements each cycle. When cnt==0, next state is RUN.
- DRAIN: pc_write=0, IF_IDwrite=0, id_ex_bubble=1. cnt decrements. When cnt==0, next state is HALTED.
- HALTED: halted=1, pc_write=0, IF_IDwrite=0, id_ex_bubble=1.
  - On resume: pc_write=1, IF_IDwrite=1, if_id_flush=1, which discards the held HALT. Next state RUN.
- resume is ignored outside HALTED.
- cnt is a 4-bit down-counter. It never wraps, because it is only decremented while nonzero or on the exit cycle.

## Timing
- Outputs are combinational from the current state and inputs, with zero latency. State and cnt are registered.
- While rst_n=0, regardless of clock:
  - state=RUN, cnt=0
  - outputs forced to pc_write=0, IF_IDwrite=0, if_id_flush=0, id_ex_bubble=1, ex_hold=0, halted=0, ctrl_state=0
  - stall_cycles=0 when present
- Reset asserted mid-MC_WAIT or mid-DRAIN aborts the operation immediately. After release, the first edge evaluates RUN.
- A multi-cycle op freezes the front end for exactly MC_LAT cycles, counting the ex_mc_start cycle.
- A halt gives 1 RUN cycle, then 3 DRAIN cycles, then HALTED. halted rises 4 cycles after the cycle in which HALT is detected.
- Resume takes 1 cycle: flush occurs on the resume cycle, and the core is back in RUN on the next cycle.

## Configuration
- STALL_CNT_EN defined:
  - adds output port stall_cycles (out, CNT_W).
  - Increments on every clock with rst_n=1, pc_write=0 and state != HALTED.
  - Saturates at all-ones and resets to 0.
- STALL_CNT_EN undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset: enter MC_WAIT, then drive rst_n=0 → outputs immediately take reset values and ctrl_state=0. After release with no hazards, pc_write=1 and IF_IDwrite=1.
- Load-use: ex_valid=1, ex_memread=1, ex_rd=3, id_valid=1, id_rs1=3 for one cycle → exactly 1 cycle of pc_write=0, IF_IDwrite=0, id_ex_bubble=1.
  - Same stimulus with ex_rd=0 → no stall.
  - id_rs2=3 with id_uses_rs2=0 → no stall.
- Multi-cycle (MC_LAT=4): one-cycle ex_mc_start pulse → ex_hold=1 and pc_write=0 for exactly 4 cycles; cycle 5 returns to pc_write=1. ex_branch_taken=1 during MC_WAIT → no flush.
- Branch priority: ex_branch_taken=1 together with LU=1 and id_halt=1 → if_id_flush=1, id_ex_bubble=1, pc_write=1; next state RUN.
- Halt/resume: id_halt at cycle 0 → ctrl_state 2 in cycles 1–3, halted=1 from cycle 4. resume at cycle 6 → if_id_flush=1 and pc_write=1 in cycle 6; ctrl_state=0 in cycle 7.
- STALL_CNT_EN: reset, then a multi-cycle op (MC_LAT=4), then one load-use stall → stall_cycles=5. Cycles spent in HALTED do not count.
